// File: rtl/soc_rst_ctrl.sv
// Reset conditioner: power-on hold plus a synchronised, debounced pushbutton reset.
// The SoC reset is held for a fixed number of cycles after every reset cause ends.
`timescale 1ns/1ps
module soc_rst_ctrl #(
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       rstc_clk_i,
  input  logic       rstc_rst_i,
  input  logic       rstc_btn_i,
  output logic       rstc_soc_rst_o,
  output logic [1:0] rstc_state_o,
  output logic [7:0] rstc_press_cnt_o
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > DEBOUNCE_CYCLES) ? HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DEBOUNCE = 2'd2,
    ST_PRESSED  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   soc_rst_q, soc_rst_d;
  logic [7:0]             press_cnt_q, press_cnt_d;
  logic                   btn_pressed;

  assign sync_d[0] = rstc_btn_i;
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign btn_pressed = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    soc_rst_d   = soc_rst_q;
    press_cnt_d = press_cnt_q;
    case (state_q)
      ST_HOLD: begin
        soc_rst_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          soc_rst_d = 1'b0;
        end
      end
      ST_RUN: begin
        soc_rst_d = 1'b0;
        cnt_d     = '0;
        if (btn_pressed) begin
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        soc_rst_d = 1'b0;
        if (!btn_pressed) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          // Reset rises on the accepting edge itself, not one cycle later.
          state_d   = ST_PRESSED;
          cnt_d     = '0;
          soc_rst_d = 1'b1;
          if (press_cnt_q != 8'hFF) begin
            press_cnt_d = press_cnt_q + 8'd1;
          end
        end
      end
      ST_PRESSED: begin
        soc_rst_d = 1'b1;
        if (btn_pressed) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        soc_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge rstc_clk_i or posedge rstc_rst_i) begin
    if (rstc_rst_i) begin
      sync_q      <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      soc_rst_q   <= 1'b1;
      press_cnt_q <= 8'd0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      soc_rst_q   <= soc_rst_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign rstc_soc_rst_o   = soc_rst_q;
  assign rstc_state_o     = state_q;
  assign rstc_press_cnt_o = press_cnt_q;

endmodule
